score_display_scheduler: RTL and testbench

//  Owns the 4-digit 7-segment display (Dis/T) on the catch board and shares it between two

---
 rtl/score_display_scheduler.sv | 142 ++++++++++++++
 tb/tb_score_display_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_display_scheduler.sv
// Shares the catch-board 4-digit 7-segment display between two BCD score writers.
// Round-robin arbiter for the writes; multiplexed anode scan with a trailing blank gap per slot.
module score_display_scheduler #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic       Clock,
    input  logic       InReset,
    input  logic       P1Req,
    input  logic [7:0] P1Score,
    output logic       P1Ack,
    input  logic       P2Req,
    input  logic [7:0] P2Score,
    output logic       P2Ack,
    output logic [6:0] Dis,
    output logic [3:0] T
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] lastCount       = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] blankStartCount = CW'(CLK_DIV - BLANK_CYC - 1);
    localparam bit            hasBlank        = (BLANK_CYC > 0);

    typedef enum logic {
        StDrive,
        StBlank
    } scanState_t;

    scanState_t    state;
    scanState_t    nextState;
    logic [CW-1:0] divCount;
    logic [1:0]    digitIdx;
    logic [1:0]    nextIdx;
    logic [3:0]    nextNibble;
    logic [7:0]    p1Value;
    logic [7:0]    p2Value;
    logic          rrP2First;
    logic          p1Eligible;
    logic          p2Eligible;
    logic          grantP1;
    logic          grantP2;

    function automatic logic [6:0] segDecode(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b0111111;
        endcase
        return seg;
    endfunction

    // A player whose Ack is currently high is masked so a held Req is not double-granted.
    assign p1Eligible = P1Req & ~P1Ack;
    assign p2Eligible = P2Req & ~P2Ack;
    assign grantP1    = p1Eligible & (~p2Eligible | ~rrP2First);
    assign grantP2    = p2Eligible & (~p1Eligible |  rrP2First);

    always_ff @(posedge Clock or negedge InReset) begin
        if (!InReset) begin
            p1Value   <= 8'h00;
            p2Value   <= 8'h00;
            P1Ack     <= 1'b0;
            P2Ack     <= 1'b0;
            rrP2First <= 1'b0;
        end else begin
            P1Ack <= grantP1;
            P2Ack <= grantP2;
            if (grantP1) begin
                p1Value <= P1Score;
            end
            if (grantP2) begin
                p2Value <= P2Score;
            end
            if (p1Eligible && p2Eligible) begin
                rrP2First <= ~rrP2First;
            end
        end
    end

    // Blank gap occupies the last BLANK_CYC counts of each slot, so the digit lit out of reset gets its full lit time first.
    always_comb begin
        nextState = state;
        nextIdx   = digitIdx;
        case (state)
            StDrive: begin
                if (hasBlank && divCount == blankStartCount) begin
                    nextState = StBlank;
                end else if (!hasBlank && divCount == lastCount) begin
                    nextIdx = digitIdx + 2'd1;
                end
            end
            StBlank: begin
                if (divCount == lastCount) begin
                    nextState = StDrive;
                    nextIdx   = digitIdx + 2'd1;
                end
            end
            default: nextState = StDrive;
        endcase
    end

    always_comb begin
        case (nextIdx)
            2'd0:    nextNibble = p2Value[3:0];
            2'd1:    nextNibble = p2Value[7:4];
            2'd2:    nextNibble = p1Value[3:0];
            default: nextNibble = p1Value[7:4];
        endcase
    end

    // T and Dis are both loaded from the next scan state on the same edge, so anode and segments never disagree.
    always_ff @(posedge Clock or negedge InReset) begin
        if (!InReset) begin
            divCount <= '0;
            state    <= StDrive;
            digitIdx <= 2'd0;
            T        <= 4'b1110;
            Dis      <= 7'b1000000;
        end else begin
            divCount <= (divCount == lastCount) ? '0 : divCount + CW'(1);
            state    <= nextState;
            digitIdx <= nextIdx;
            if (nextState == StBlank) begin
                T   <= 4'b1111;
                Dis <= 7'b1111111;
            end else begin
                T   <= ~(4'b0001 << nextIdx);
                Dis <= segDecode(nextNibble);
            end
        end
    end

endmodule

// File: tb/tb_score_display_scheduler.sv
// Scoreboard bench for score_display_scheduler with CLK_DIV=8, BLANK_CYC=2.
// Directed writes push expected acks/display samples; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_score_display_scheduler;

    logic       Clock;
    logic       InReset;
    logic       P1Req;
    logic [7:0] P1Score;
    logic       P1Ack;
    logic       P2Req;
    logic [7:0] P2Score;
    logic       P2Ack;
    logic [6:0] Dis;
    logic [3:0] T;

    typedef struct {
        int player;
        int cycle;
    } ackExp_t;

    typedef struct {
        int         cycle;
        logic [3:0] t;
        logic [6:0] dis;
    } dispExp_t;

    ackExp_t  ackQ[$];
    dispExp_t dispQ[$];
    dispExp_t monD;
    int       cyc;
    int       vectors;
    int       miscompares;

    score_display_scheduler #(
        .CLK_DIV  (8),
        .BLANK_CYC(2)
    ) dut (
        .Clock  (Clock),
        .InReset(InReset),
        .P1Req  (P1Req),
        .P1Score(P1Score),
        .P1Ack  (P1Ack),
        .P2Req  (P2Req),
        .P2Score(P2Score),
        .P2Ack  (P2Ack),
        .Dis    (Dis),
        .T      (T)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Cycle stamp: number of rising edges since reset release.
    always @(posedge Clock or negedge InReset) begin
        if (!InReset) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    task automatic checkAck(input int player);
        ackExp_t e;
        if (ackQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected ack at cycle %0d: got player %0d, expected none", cyc, player);
        end else begin
            e = ackQ.pop_front();
            checkOutput("ack player", player, e.player);
            checkOutput("ack cycle", cyc, e.cycle);
        end
    endtask

    always @(negedge Clock) begin
        if (InReset) begin
            if (P1Ack) checkAck(1);
            if (P2Ack) checkAck(2);
            while (dispQ.size() > 0 && dispQ[0].cycle <= cyc) begin
                monD = dispQ.pop_front();
                if (monD.cycle < cyc) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL display sample missed: got cycle %0d, expected %0d", cyc, monD.cycle);
                end else begin
                    checkOutput("scan T", {28'd0, T}, {28'd0, monD.t});
                    checkOutput("scan Dis", {25'd0, Dis}, {25'd0, monD.dis});
                end
            end
        end
    end

    task automatic applyStimulus(input logic r1, input logic [7:0] s1, input logic r2, input logic [7:0] s2);
        P1Req   = r1;
        P1Score = s1;
        P2Req   = r2;
        P2Score = s2;
    endtask

    task automatic expectAck(input int player, input int cycle);
        ackExp_t e;
        e.player = player;
        e.cycle  = cycle;
        ackQ.push_back(e);
    endtask

    // Digit d is lit at cycles 8d..8d+5 of every 32-cycle scan; queue the next full window and wait it out.
    task automatic expectDigit(input int d, input logic [3:0] tExp, input logic [6:0] disExp);
        dispExp_t e;
        int s;
        s = 8 * d;
        while (s < cyc + 2) s += 32;
        for (int i = 0; i < 6; i++) begin
            e.cycle = s + i;
            e.t     = tExp;
            e.dis   = disExp;
            dispQ.push_back(e);
        end
        while (cyc < s + 6) @(negedge Clock);
    endtask

    // One full scan from reset with all-zero scores: 6 lit "0" cycles then 2 blank per digit.
    task automatic pushScan();
        dispExp_t   e;
        logic [3:0] litT [4];
        litT = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int k = 0; k < 32; k++) begin
            e.cycle = k;
            if (k % 8 < 6) begin
                e.t   = litT[k / 8];
                e.dis = 7'b1000000;
            end else begin
                e.t   = 4'b1111;
                e.dis = 7'b1111111;
            end
            dispQ.push_back(e);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        InReset     = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (3) @(posedge Clock);
        #2;
        checkOutput("reset T", {28'd0, T}, 32'h0000000E);
        checkOutput("reset Dis", {25'd0, Dis}, 32'h00000040);
        checkOutput("reset P1Ack", {31'd0, P1Ack}, 32'd0);
        checkOutput("reset P2Ack", {31'd0, P2Ack}, 32'd0);

        // Scan order and blank gap straight out of reset.
        pushScan();
        @(posedge Clock);
        #2 InReset = 1'b1;
        while (cyc < 32) @(negedge Clock);

        // Single P1 write of 47.
        applyStimulus(1'b1, 8'h47, 1'b0, 8'h00);
        expectAck(1, cyc + 1);
        @(negedge Clock);
        applyStimulus(1'b0, 8'h47, 1'b0, 8'h00);
        repeat (2) @(negedge Clock);
        expectDigit(3, 4'b0111, 7'b0011001);
        expectDigit(2, 4'b1011, 7'b1111000);

        // Simultaneous requests: P1 wins first, then pointer favours P2.
        applyStimulus(1'b1, 8'h12, 1'b1, 8'h34);
        expectAck(1, cyc + 1);
        expectAck(2, cyc + 2);
        @(negedge Clock);
        applyStimulus(1'b0, 8'h12, 1'b1, 8'h34);
        @(negedge Clock);
        applyStimulus(1'b0, 8'h12, 1'b0, 8'h34);
        repeat (2) @(negedge Clock);
        applyStimulus(1'b1, 8'h56, 1'b1, 8'h78);
        expectAck(2, cyc + 1);
        expectAck(1, cyc + 2);
        @(negedge Clock);
        applyStimulus(1'b1, 8'h56, 1'b0, 8'h78);
        @(negedge Clock);
        applyStimulus(1'b0, 8'h56, 1'b0, 8'h78);
        repeat (2) @(negedge Clock);
        expectDigit(0, 4'b1110, 7'b0000000);
        expectDigit(3, 4'b0111, 7'b0010010);
        expectDigit(2, 4'b1011, 7'b0000010);

        // P2 Req held past its Ack: exactly one extra capture.
        applyStimulus(1'b0, 8'h56, 1'b1, 8'h09);
        expectAck(2, cyc + 1);
        expectAck(2, cyc + 3);
        repeat (3) @(negedge Clock);
        applyStimulus(1'b0, 8'h56, 1'b0, 8'h09);
        repeat (3) @(negedge Clock);
        expectDigit(0, 4'b1110, 7'b0010000);
        expectDigit(1, 4'b1101, 7'b1000000);

        // Non-BCD tens nibble shows a dash.
        applyStimulus(1'b0, 8'h56, 1'b1, 8'hA5);
        expectAck(2, cyc + 1);
        @(negedge Clock);
        applyStimulus(1'b0, 8'h56, 1'b0, 8'hA5);
        repeat (2) @(negedge Clock);
        expectDigit(1, 4'b1101, 7'b0111111);
        expectDigit(0, 4'b1110, 7'b0010010);

        // Asynchronous reset in the middle of a blank gap.
        while (cyc % 8 != 6) @(negedge Clock);
        checkOutput("pre-reset blank T", {28'd0, T}, 32'h0000000F);
        #1 InReset = 1'b0;
        #1;
        checkOutput("async reset T", {28'd0, T}, 32'h0000000E);
        checkOutput("async reset Dis", {25'd0, Dis}, 32'h00000040);
        checkOutput("async reset P2Ack", {31'd0, P2Ack}, 32'd0);
        pushScan();
        @(posedge Clock);
        #2 InReset = 1'b1;
        while (cyc < 32) @(negedge Clock);

        // Requests pending across reset release are re-arbitrated with P1 first.
        @(negedge Clock);
        InReset = 1'b0;
        applyStimulus(1'b1, 8'h21, 1'b1, 8'h43);
        expectAck(1, 1);
        expectAck(2, 2);
        @(posedge Clock);
        #2 InReset = 1'b1;
        repeat (2) @(negedge Clock);
        applyStimulus(1'b0, 8'h21, 1'b1, 8'h43);
        @(negedge Clock);
        applyStimulus(1'b0, 8'h21, 1'b0, 8'h43);
        repeat (3) @(negedge Clock);
        expectDigit(2, 4'b1011, 7'b1111001);
        expectDigit(3, 4'b0111, 7'b0100100);
        expectDigit(0, 4'b1110, 7'b0110000);
        repeat (2) @(negedge Clock);

        if (ackQ.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL missing acks: got %0d outstanding, expected 0", ackQ.size());
        end
        if (dispQ.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unchecked display samples: got %0d outstanding, expected 0", dispQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
